// File: rtl/led_seq_ctrl_pkg.sv
// led_seq_ctrl_pkg
// Shared definitions for the LED sequencer: FSM state encoding, default
// step count, the latched playback configuration record and the four
// pattern bank tables used by led_pattern_rom.
package led_seq_ctrl_pkg;

  // FSM encoding kept as plain constants so older code can compare raw values
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int DEF_NUM_STEPS = 6;

  // Number of entries physically stored per bank
  localparam int TABLE_STEPS = 6;

  // Playback configuration captured on start (hold is kept separately
  // because its width is a module parameter)
  typedef struct packed {
    logic [1:0] mode;
    logic       dir;
    logic       one_shot;
  } cfg_t;

  // BANK_TABLE[bank][index]
  localparam logic [3:0] BANK_TABLE [4][TABLE_STEPS] = '{
    '{4'b1111, 4'b1010, 4'b0101, 4'b0000, 4'b1110, 4'b0111},
    '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010},
    '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011},
    '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000}
  };

endpackage

// File: rtl/led_pattern_rom.sv
// led_pattern_rom
// Combinational lookup of a 4-bit LED pattern from (bank, index).
// Indices at or beyond NUM_STEPS (or beyond the stored table) read 0000.
// Ports:
//   i_mode    - bank select
//   i_idx     - step index
//   o_pattern - pattern for that bank/index
module led_pattern_rom
  import led_seq_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS
) (
  input  logic [1:0] i_mode,
  input  logic [2:0] i_idx,
  output logic [3:0] o_pattern
);

  always_comb begin
    o_pattern = 4'b0000;
    if ((int'(i_idx) < NUM_STEPS) && (int'(i_idx) < TABLE_STEPS)) begin
      o_pattern = BANK_TABLE[i_mode][i_idx];
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
// LED pattern sequencer. A start pulse latches the playback configuration
// and steps through one of four pattern banks, dwelling hold+1 cycles per
// step, ascending or descending, looping or single-pass. Playback can be
// paused, single-stepped while paused, or aborted with stop.
// Ports:
//   clk_divider_wire - clock, rising edge
//   rst              - asynchronous active-low reset
//   start / stop     - playback begin / abort pulses
//   pause            - level, freezes playback while high
//   step_req         - advance one step while paused
//   dir, one_shot, mode, hold - playback configuration, sampled on start
//   LEDR             - registered pattern output
//   step_idx         - current step index
//   busy             - high outside IDLE
//   wrap             - one-cycle pulse when the index wraps
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int HOLD_W    = 4
) (
  input  logic              clk_divider_wire,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              step_req,
  input  logic              dir,
  input  logic              one_shot,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  output logic [3:0]        LEDR,
  output logic [2:0]        step_idx,
  output logic              busy,
  output logic              wrap
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_STEPS - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_idx;
  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] r_hold;
  cfg_t              r_cfg;
  logic [3:0]        r_ledr;
  logic              r_busy;
  logic              r_wrap;

  logic [1:0]        w_state_next;
  logic [2:0]        w_idx_next;
  logic [HOLD_W-1:0] w_cnt_next;
  logic [HOLD_W-1:0] w_hold_next;
  cfg_t              w_cfg_next;
  logic              w_wrap_next;
  logic              w_do_adv;
  logic [2:0]        w_adv_idx;
  logic              w_adv_wrap;
  logic [3:0]        w_pattern;

  // Neighbouring index in the latched direction, wrapping at either end
  always_comb begin
    if (!r_cfg.dir) begin
      w_adv_wrap = (r_idx == LAST_IDX);
      w_adv_idx  = w_adv_wrap ? 3'd0 : r_idx + 3'd1;
    end else begin
      w_adv_wrap = (r_idx == 3'd0);
      w_adv_idx  = w_adv_wrap ? LAST_IDX : r_idx - 3'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_hold_next  = r_hold;
    w_cfg_next   = r_cfg;
    w_wrap_next  = 1'b0;
    w_do_adv     = 1'b0;
    if (stop) begin
      w_state_next = ST_IDLE;
      w_idx_next   = 3'd0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_cfg_next.mode     = mode;
            w_cfg_next.dir      = dir;
            w_cfg_next.one_shot = one_shot;
            w_hold_next         = hold;
            w_idx_next          = dir ? LAST_IDX : 3'd0;
            w_cnt_next          = '0;
            w_state_next        = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (pause) begin
            w_state_next = ST_PAUSE;
          end else if (r_cnt == r_hold) begin
            w_do_adv = 1'b1;
          end else begin
            w_cnt_next = r_cnt + HOLD_W'(1);
          end
        end
        ST_PAUSE: begin
          // Dwell counter is left untouched so SHOW resumes mid-step
          if (!pause) begin
            w_state_next = ST_SHOW;
          end else if (step_req) begin
            w_do_adv = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_idx_next   = 3'd0;
          w_cnt_next   = '0;
        end
      endcase
      if (w_do_adv) begin
        w_cnt_next  = '0;
        w_idx_next  = w_adv_idx;
        w_wrap_next = w_adv_wrap;
        // A single pass ends on the wrap; the wrap pulse is still reported
        if (w_adv_wrap && r_cfg.one_shot) begin
          w_state_next = ST_IDLE;
          w_idx_next   = 3'd0;
        end
      end
    end
  end

  // Looked up from next-cycle values so LEDR tracks the index with no lag
  led_pattern_rom #(
    .NUM_STEPS (NUM_STEPS)
  ) u_rom (
    .i_mode    (w_cfg_next.mode),
    .i_idx     (w_idx_next),
    .o_pattern (w_pattern)
  );

  always_ff @(posedge clk_divider_wire or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_cfg   <= '0;
      r_ledr  <= 4'b0000;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_hold  <= w_hold_next;
      r_cfg   <= w_cfg_next;
      r_ledr  <= (w_state_next == ST_IDLE) ? 4'b0000 : w_pattern;
      r_busy  <= (w_state_next != ST_IDLE);
      r_wrap  <= w_wrap_next;
    end
  end

  assign LEDR     = r_ledr;
  assign step_idx = r_idx;
  assign busy     = r_busy;
  assign wrap     = r_wrap;

endmodule
